fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Drains bytes from the upstream ping-pong byte FIFO and serialises them onto an async UART line (LSB first, 8 data bits).
//  Sits directly downstream of the FIFO: watches its empty flag, issues read strobes and latches the byte the FIFO presents.
//  Single clock domain. The FIFO read strobe is generated from clk.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal range 4..65535
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, asynchronous, active-low
//  fifo_empty   in   1   FIFO empty flag; a read is issued only while this is low
//  fifo_dat     in   8   FIFO read data; valid from the 2nd clk edge after fifo_rd rises
//  fifo_rd      out  1   FIFO read strobe; 1-clk high pulse, rising edge pops one byte
//  tx           out  1   UART serial output; idle high
//  busy         out  1   high from FETCH entry until the last stop bit completes
//  tx_cnt       out  16  bytes transmitted; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE, fifo_rd=0, tx=1, busy=0, tx_cnt=0, shift reg=0, bit/baud counters=0.
//  Reset mid-frame aborts immediately: tx returns high in the same cycle, and the partial byte is lost.
//  FSM states: IDLE, FETCH, WAIT, START, DATA, [PARITY], STOP.
//   IDLE : tx=1. If fifo_empty==0 -> FETCH (fifo_rd=1 for exactly this cycle, busy=1).
//   FETCH: 1 cycle. -> WAIT.
//   WAIT : 1 cycle. At this edge, latch fifo_dat into shift reg and -> START.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA : tx=shift[0]. Shift right every CLKS_PER_BIT cycles. After 8 bits -> PARITY (if enabled) else STOP.
//   STOP : tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle: tx_cnt+=1.
//          If fifo_empty==0 -> FETCH directly (back-to-back, no idle bit). Otherwise -> IDLE with busy=0.
//  Latency: fifo_empty falling in IDLE -> tx start-bit edge 3 clk later (IDLE, FETCH, WAIT).
//  Baud counter: counts 0..CLKS_PER_BIT-1 and reloads 0 on each bit boundary. Width = $clog2(CLKS_PER_BIT).
//  fifo_rd is never asserted while fifo_empty==1, and never twice per byte.
//  fifo_empty toggling during START/DATA/STOP is ignored; it is sampled only in IDLE and on the last STOP cycle.
//  Frame length: (10 + STOP_BITS - 1 [+1 parity]) * CLKS_PER_BIT clk.
// CONFIGURATION
//  Macro UART_TX_PARITY_EN:
//   defined    : PARITY state inserted after DATA, 1 bit time, tx = even parity (XOR of 8 data bits).
//   undefined  : no PARITY state, DATA -> STOP; parity logic absent.
// STRUCTURE
//  Package uart_pkg: state enum (tx_state_t, 3-bit encoding), IDLE_LEVEL=1'b1, START_LEVEL=1'b0, DATA_BITS=8.
//  Sub-module uart_baud_gen (CLKS_PER_BIT): free counter with sync restart and a 1-clk bit_tick output.
//  The top level instantiates uart_baud_gen once; the FSM, shift reg and tx_cnt live in fifo_uart_tx.
// TESTING (CLKS_PER_BIT=4 for speed; bench models the FIFO read timing)
//  1. Reset then idle with fifo_empty=1 for 100 clk -> tx=1, fifo_rd never pulses, busy=0, tx_cnt=0.
//  2. Single byte 0xA5 -> one fifo_rd pulse. tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clk. tx_cnt=1, busy drops after stop.
//  3. Three bytes 0x00,0xFF,0x3C queued -> 3 back-to-back frames, each byte gets its own FETCH+WAIT, no extra idle bits.
//     3 fifo_rd pulses total, tx_cnt=3.
//  4. rst pulsed low mid-DATA of 0x55 -> tx=1 and busy=0 asynchronously. Next byte after reset transmits cleanly.
//  5. UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after D7. Byte 0x03 -> parity bit 0. Frame = 11 bit times.
//  6. STOP_BITS=2, byte 0x81 -> stop high for 8 clk. tx_cnt preloaded to 0xFFFF wraps to 0 after the frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the state encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int   DATA_BITS   = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_tick
// on the last count; restart holds it at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and sends them as 8N1/8N2 UART frames.
// Define UART_TX_PARITY_EN to append an even-parity bit after D7.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dat,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic [15:0] tx_cnt
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        restart, bit_tick;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  // Bit timing starts fresh with the start bit of every frame.
  assign restart = (state_q == IDLE) ||
                   (state_q == FETCH) ||
                   (state_q == WAIT);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    fifo_rd_d = 1'b0;
    tx_cnt_d  = tx_cnt_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (!fifo_empty) begin
          state_d   = FETCH;
          fifo_rd_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        shift_d = fifo_dat;
`ifdef UART_TX_PARITY_EN
        par_d   = ^fifo_dat;
`endif
        bit_d   = '0;
        tx_d    = START_LEVEL;
        state_d = START;
      end
      START: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = IDLE_LEVEL;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          tx_d    = IDLE_LEVEL;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d    = '0;
            tx_cnt_d = tx_cnt_q + 16'd1;
            // Chain straight into the next byte when one is waiting.
            if (!fifo_empty) begin
              state_d   = FETCH;
              fifo_rd_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      fifo_rd_q <= 1'b0;
      tx_cnt_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      fifo_rd_q <= fifo_rd_d;
      tx_cnt_q  <= tx_cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign fifo_rd = fifo_rd_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_cnt  = tx_cnt_q;

endmodule
